// File: rtl/dcache_scratchpad_resp_pkg.sv
// Shared types for the scratchpad-backed dcache responder: memory command
// encodings, access-size enum, response pipeline stage and alignment helper.
package dcache_scratchpad_resp_pkg;

    localparam logic [4:0] M_XRD = 5'b00000;
    localparam logic [4:0] M_XWR = 5'b00001;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_e;

    // One response pipeline slot. The tag travels in a parallel array because
    // its width is a per-instance parameter.
    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic        nack;
        logic        ma_ld;
        logic        ma_st;
    } resp_stage_t;

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input mem_size_e size);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dcache_scratchpad_resp_lane_align.sv
// Byte-lane steering for the scratchpad: store data shift plus byte mask,
// and load lane extract with sign/zero extension.
module dcache_lane_align
    import dcache_scratchpad_resp_pkg::*;
(
    input  logic [2:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] st_data,
    output logic [63:0] st_word,
    output logic [7:0]  st_mask,
    input  logic [63:0] ld_word,
    output logic [63:0] ld_data
);

    logic [5:0]  shamt;
    logic [7:0]  base_mask;
    logic [63:0] ld_shift;

    assign shamt = {addr_lo, 3'b000};

    // store side: move LSB-aligned data into its lane and enable only its bytes
    always_comb begin
        base_mask = 8'h00;
        case (mem_size_e'(size))
            SIZE_B:  base_mask = 8'h01;
            SIZE_H:  base_mask = 8'h03;
            SIZE_W:  base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        st_mask = base_mask << addr_lo;
        st_word = st_data << shamt;
    end

    // load side: bring the addressed lane down to bit 0 and extend it
    always_comb begin
        ld_shift = ld_word >> shamt;
        ld_data  = ld_shift;
        case (mem_size_e'(size))
            SIZE_B:  ld_data = is_unsigned ? {56'd0, ld_shift[7:0]}
                                           : {{56{ld_shift[7]}}, ld_shift[7:0]};
            SIZE_H:  ld_data = is_unsigned ? {48'd0, ld_shift[15:0]}
                                           : {{48{ld_shift[15]}}, ld_shift[15:0]};
            SIZE_W:  ld_data = is_unsigned ? {32'd0, ld_shift[31:0]}
                                           : {{32{ld_shift[31]}}, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/dcache_scratchpad_resp.sv
// Fixed-latency dcache responder backed by a 64-bit-word scratchpad.
// Handles load/store sizing, tag echo, kill, misalignment exceptions and nacks.
// Optional feature: define DCACHE_RESP_NACK_INJECT_EN to nack every
// NACK_PERIOD-th accepted legal aligned load.
module dcache_scratchpad_resp
    import dcache_scratchpad_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned TAG_W       = 8,
    parameter int unsigned NACK_PERIOD = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [4:0]       req_cmd_i,
    input  logic [39:0]      req_addr_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_unsigned_i,
    input  logic [63:0]      req_data_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             req_kill_i,
    output logic             resp_valid_o,
    output logic [63:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             resp_nack_o,
    output logic             xcpt_ma_ld_o,
    output logic             xcpt_ma_st_o
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic [63:0]      mem [MEM_WORDS];
    logic             ready_q;
    resp_stage_t      pipe_q [LATENCY];
    logic [TAG_W-1:0] tag_q  [LATENCY];

    logic             accept;
    logic             is_ld;
    logic             is_st;
    logic             out_of_range;
    logic             misaligned;
    logic             inj_nack;
    logic             nack;
    logic             do_store;
    logic             s0_live_valid;
    logic [IDX_W-1:0] idx;
    logic [63:0]      rd_word;
    logic [63:0]      st_word;
    logic [63:0]      ld_data;
    logic [7:0]       st_mask;
    resp_stage_t      s0_next;
    resp_stage_t      last;
    logic             last_valid;

    assign accept       = req_valid_i && ready_q;
    assign is_ld        = (req_cmd_i == M_XRD);
    assign is_st        = (req_cmd_i == M_XWR);
    assign idx          = req_addr_i[IDX_W+2:3];
    assign out_of_range = |req_addr_i[39:IDX_W+3];
    assign misaligned   = is_misaligned(req_addr_i[2:0], mem_size_e'(req_size_i));
    assign rd_word      = mem[idx];
    assign req_ready_o  = ready_q;

    dcache_lane_align u_lane_align (
        .addr_lo     (req_addr_i[2:0]),
        .size        (req_size_i),
        .is_unsigned (req_unsigned_i),
        .st_data     (req_data_i),
        .st_word     (st_word),
        .st_mask     (st_mask),
        .ld_word     (rd_word),
        .ld_data     (ld_data)
    );

`ifdef DCACHE_RESP_NACK_INJECT_EN
    localparam int unsigned CNT_W = (NACK_PERIOD > 1) ? $clog2(NACK_PERIOD) : 1;

    logic [CNT_W-1:0] ld_cnt_q;
    logic             legal_ld;

    assign legal_ld = accept && is_ld && !out_of_range && !misaligned;
    assign inj_nack = legal_ld && (ld_cnt_q == CNT_W'(NACK_PERIOD - 1));

    // count legal aligned loads; the one landing on NACK_PERIOD-1 is nacked and wraps
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ld_cnt_q <= '0;
        end else if (legal_ld) begin
            ld_cnt_q <= inj_nack ? '0 : ld_cnt_q + 1'b1;
        end
    end
`else
    assign inj_nack = 1'b0;
`endif

    assign nack     = !(is_ld || is_st) || out_of_range || inj_nack;
    assign do_store = accept && is_st && !nack && !misaligned;

    // classify the accepted request into the stage-0 response record
    always_comb begin
        s0_next       = '0;
        s0_next.valid = accept;
        if (accept) begin
            if (nack) begin
                s0_next.nack = 1'b1;
            end else if (misaligned) begin
                s0_next.ma_ld = is_ld;
                s0_next.ma_st = is_st;
            end else if (is_ld) begin
                s0_next.data = ld_data;
            end
        end
    end

    // scratchpad write port: byte lanes enabled by the store mask, contents not reset
    always_ff @(posedge clk_i) begin
        if (do_store) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (st_mask[b]) begin
                    mem[idx][8*b +: 8] <= st_word[8*b +: 8];
                end
            end
        end
    end

    // ready drops for the single cycle after any nacked accept
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= !(accept && nack);
        end
    end

    // a kill lands while the request sits in stage 0, so it gates that slot's valid
    assign s0_live_valid = pipe_q[0].valid && !req_kill_i;

    // response shift register; stage 0 loads every cycle, kill applied on the way out of it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            pipe_q[0] <= s0_next;
            tag_q[0]  <= req_tag_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
                tag_q[i]  <= tag_q[i-1];
                if (i == 1) begin
                    pipe_q[i].valid <= s0_live_valid;
                end
            end
        end
    end

    // drive the response from the last stage; idle outputs are held at zero
    always_comb begin
        last         = pipe_q[LATENCY-1];
        last_valid   = (LATENCY == 1) ? s0_live_valid : last.valid;
        resp_valid_o = last_valid;
        resp_data_o  = last_valid ? last.data : '0;
        resp_tag_o   = last_valid ? tag_q[LATENCY-1] : '0;
        resp_nack_o  = last_valid && last.nack;
        xcpt_ma_ld_o = last_valid && last.ma_ld;
        xcpt_ma_st_o = last_valid && last.ma_st;
    end

endmodule

// File: doc/dcache_scratchpad_resp.md
Name: dcache_scratchpad_resp

Overview:
- Synthesizable fixed-latency data-memory responder. It sits on the dcache side of the exe-stage memory interface: it accepts cpu→dcache requests and returns dcache→cpu responses.
- Backed by a 64-bit-word scratchpad. Used for exe-stage unit benches and small SoC configurations without a real L1D.
- Models load/store sizing, tag return, request kill, misalignment exceptions and nacks.

Parameters:
- MEM_WORDS, 256, number of 64-bit scratchpad words. Power of two.
- LATENCY, 2, cycles from request accept to response. Range 1..4.
- TAG_W, 8, request/response tag width.
- NACK_PERIOD, 4, with the optional feature enabled, every NACK_PERIOD-th accepted load is nacked.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  responder can accept
- req_cmd_i  in  5  5'b00000 = load, 5'b00001 = store; any other value is nacked
- req_addr_i  in  40  byte address
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned_i  in  1  zero-extend load result
- req_data_i  in  64  store data, LSB-aligned
- req_tag_i  in  TAG_W  request tag
- req_kill_i  in  1  kill the request accepted in the previous cycle
- resp_valid_o  out  1  response valid (single-cycle pulse)
- resp_data_o  out  64  extended load data; 0 for stores
- resp_tag_o  out  TAG_W  echoed tag
- resp_nack_o  out  1  request not performed; requester replays
- xcpt_ma_ld_o  out  1  misaligned load
- xcpt_ma_st_o  out  1  misaligned store

Behaviour:
- Reset: every output is 0 except req_ready_o. All pipeline valid bits are cleared. Scratchpad contents are not reset.
- req_ready_o:
  - 1 after reset.
  - Drops to 0 for exactly the one cycle following any nacked request (replay spacing).
- Accept when req_valid_i && req_ready_o. One request per cycle. No response backpressure.
- Index = req_addr_i[log2(MEM_WORDS)+2:3]. Out of range when any bit of req_addr_i[39:log2(MEM_WORDS)+3] is set.
- Misaligned when the address is not a multiple of 2^size. A misaligned request has no memory effect and returns its exception flag with the normal latency, nack = 0.
- Priority at accept:
  1. illegal cmd or out of range → nack
  2. misaligned → exception
  3. perform the access
- Store:
  - Memory is written in the accept cycle. The byte-enable mask is derived from size and addr[2:0]; data is shifted into its lane.
- Load:
  - Memory is read in the accept cycle, so a store accepted in cycle N is visible to a load accepted in cycle N+1.
  - Lane select by addr[2:0], then sign- or zero-extend per req_unsigned_i. Dword ignores req_unsigned_i.
- Pipeline:
  - LATENCY-deep shift register of {valid, tag, data, nack, ma_ld, ma_st}.
  - resp_valid_o asserts exactly LATENCY cycles after accept.
  - Back-to-back accepts produce back-to-back responses in order.
- Kill:
  - req_kill_i in cycle N+1 clears the stage-0 valid bit of a request accepted in cycle N. No response is produced.
  - A killed store has already written memory. Kill exists to drop load responses only; the requester must not kill stores.
  - req_kill_i with no request accepted in the previous cycle: ignored.
- Reset mid-operation: in-flight responses are discarded. No response appears after reset deassertion until a new accept.

Optional Feature:
- Macro: DCACHE_RESP_NACK_INJECT_EN.
- Enabled:
  - A counter of accepted, otherwise-legal aligned loads increments each such accept and is reset to 0.
  - When the count reaches NACK_PERIOD-1, that load is nacked instead of performed and the counter wraps to 0.
  - The normal one-cycle ready drop follows the nack.
- Disabled: no counter is present; only illegal or out-of-range requests nack.

Decomposition:
- Shared package (drac_pkg addition):
  - dcache_cmd constants M_XRD = 5'b00000, M_XWR = 5'b00001.
  - Size enum.
  - Typedef for the pipeline stage struct.
- One natural sub-module, dcache_lane_align: combinational store-lane shift / byte-mask generation and load-lane extract / extend.

Test Plan:
- Store dword 0x1122334455667788 @0x40, then load dword @0x40 → resp after 2 cycles with data 0x1122334455667788 and tag echoed.
- Store byte 0x80 @0x43, then load byte signed @0x43 → 0xFFFFFFFFFFFFFF80; load unsigned @0x43 → 0x80.
- Load half @0x41 → resp_valid = 1, xcpt_ma_ld_o = 1, nack = 0; store word @0x42 → xcpt_ma_st_o = 1 and memory unchanged.
- Load @0x800 with MEM_WORDS = 256 → resp_nack_o = 1, req_ready_o = 0 on the next cycle only; cmd 5'b00111 → nack.
- Load tag 5, then req_kill_i the next cycle → no response for tag 5; an unkilled load tag 6 right after still responds.
- DCACHE_RESP_NACK_INJECT_EN defined, 8 consecutive legal loads (stalling per ready) → the 4th and 8th are nacked; assert rst_i with 2 loads in flight → no resp_valid_o after release.
